// File: rtl/spi_bus_arbiter.sv
// Shares one SPI pin set between NumReq hosts, one transaction at a time, round-robin.
// Frames each ownership with CS setup/hold guard cycles and an idle gap; a watchdog reclaims hogs.
module spi_bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int CsSetupCycles = 2,
  parameter int CsHoldCycles  = 2,
  parameter int GapCycles     = 1,
  parameter int TimeoutCycles = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_i,
  output logic [NumReq-1:0]         gnt_o,
  input  logic [NumReq-1:0]         sclk_i,
  input  logic [NumReq-1:0]         copi_i,
  output logic [NumReq-1:0]         cipo_o,
  output logic                      sclk_o,
  output logic                      copi_o,
  input  logic                      cipo_i,
  output logic                      cs_no,
  output logic                      timeout_o,
  output logic [$clog2(NumReq)-1:0] owner_o
);

  localparam int IdxW   = $clog2(NumReq);
  localparam int MaxSH  = (CsSetupCycles > CsHoldCycles) ? CsSetupCycles : CsHoldCycles;
  localparam int MaxGT  = (GapCycles > TimeoutCycles) ? GapCycles : TimeoutCycles;
  localparam int MaxCnt = (MaxSH > MaxGT) ? MaxSH : MaxGT;
  localparam int CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {IDLE, SETUP, OWN, HOLD, GAP} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   winner, idx;
  logic [NumReq-1:0] blocked_q, blocked_set, eligible;
  logic              found;
  logic              timeout_q, timeout_d;
  logic              own;

  // A requester that was timed out stays ineligible until it lets go of req_i.
  assign eligible = req_i & ~blocked_q;

  // First eligible index at or after ptr, wrapping modulo NumReq.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = IdxW'((int'(ptr_q) + i) % NumReq);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    timeout_d   = 1'b0;
    blocked_set = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SETUP;
          owner_d = winner;
          ptr_d   = IdxW'((int'(winner) + 1) % NumReq);
          cnt_d   = CntW'(CsSetupCycles);
        end
      end
      SETUP: begin
        if (!req_i[owner_q]) begin
          state_d = GAP;
          cnt_d   = CntW'(GapCycles);
        end else if (cnt_q == CntW'(1)) begin
          state_d = OWN;
          cnt_d   = CntW'(TimeoutCycles);
        end
      end
      OWN: begin
        // A voluntary release in the same cycle as expiry is not a timeout.
        if (!req_i[owner_q]) begin
          state_d = HOLD;
          cnt_d   = CntW'(CsHoldCycles);
        end else if (TimeoutCycles != 0 && cnt_q == CntW'(1)) begin
          state_d              = HOLD;
          cnt_d                = CntW'(CsHoldCycles);
          timeout_d            = 1'b1;
          blocked_set[owner_q] = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CntW'(1)) begin
          state_d = GAP;
          cnt_d   = CntW'(GapCycles);
        end
      end
      GAP: begin
        if (cnt_q == CntW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      blocked_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      blocked_q <= (blocked_q | blocked_set) & req_i;
      timeout_q <= timeout_d;
    end
  end

  assign own       = (state_q == OWN);
  assign gnt_o     = own ? (NumReq'(1) << owner_q) : '0;
  assign cs_no     = !(state_q == SETUP || state_q == OWN || state_q == HOLD);
  assign timeout_o = timeout_q;
  assign owner_o   = owner_q;

  // Pin paths stay combinational so the owner's SPI bit timing reaches the bus untouched.
  assign sclk_o = own & sclk_i[owner_q];
  assign copi_o = own & copi_i[owner_q];

  always_comb begin
    cipo_o = '0;
    if (own) cipo_o[owner_q] = cipo_i;
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: two instances (watchdog off / watchdog 8) checked every cycle
// against a transaction-timeline model, plus directed scenarios and a random soak.
module tb_spi_bus_arbiter;

  localparam int N  = 2;
  localparam int S  = 2;
  localparam int H  = 2;
  localparam int G  = 1;
  localparam int TW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req      [2];
  logic [N-1:0] sclk_in  [2];
  logic [N-1:0] copi_in  [2];
  logic [N-1:0] cipo_ret [2];
  logic [N-1:0] gnt      [2];
  logic         cipo_bus [2];
  logic         sclk_bus [2];
  logic         copi_bus [2];
  logic         cs_n     [2];
  logic         tmo      [2];
  logic [0:0]   owner    [2];

  always #5 clk = ~clk;

  spi_bus_arbiter #(
    .NumReq(N), .CsSetupCycles(S), .CsHoldCycles(H), .GapCycles(G), .TimeoutCycles(0)
  ) dut_nowd (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]),
    .sclk_i(sclk_in[0]), .copi_i(copi_in[0]), .cipo_o(cipo_ret[0]),
    .sclk_o(sclk_bus[0]), .copi_o(copi_bus[0]), .cipo_i(cipo_bus[0]),
    .cs_no(cs_n[0]), .timeout_o(tmo[0]), .owner_o(owner[0])
  );

  spi_bus_arbiter #(
    .NumReq(N), .CsSetupCycles(S), .CsHoldCycles(H), .GapCycles(G), .TimeoutCycles(TW)
  ) dut_wd (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]),
    .sclk_i(sclk_in[1]), .copi_i(copi_in[1]), .cipo_o(cipo_ret[1]),
    .sclk_o(sclk_bus[1]), .copi_o(copi_bus[1]), .cipo_i(cipo_bus[1]),
    .cs_no(cs_n[1]), .timeout_o(tmo[1]), .owner_o(owner[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: one record per instance describing the current/last transaction as edge numbers.
  bit           m_active   [2];
  int           m_start    [2];
  int           m_owner    [2];
  int           m_rel      [2];
  int           m_cs_high  [2];
  int           m_free     [2];
  int           m_tmo_edge [2];
  int           m_ptr      [2];
  logic [N-1:0] m_blocked  [2];
  int           hold_left  [2][N];

  int gcnt [2];
  int clow [2];
  int tcnt [2];

  bit         track_owner = 1'b0;
  logic [0:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int t_of(input int k);
    return (k == 0) ? 0 : TW;
  endfunction

  task automatic model_reset(input int k);
    m_active[k]   = 1'b0;
    m_start[k]    = 0;
    m_owner[k]    = 0;
    m_rel[k]      = -1;
    m_cs_high[k]  = 0;
    m_free[k]     = 0;
    m_tmo_edge[k] = -1;
    m_ptr[k]      = 0;
    m_blocked[k]  = '0;
  endtask

  task automatic model_step(input int k, input logic [N-1:0] r);
    logic [N-1:0] elig;
    logic [N-1:0] set;
    bit           found;
    set = '0;
    if (m_active[k] && m_rel[k] >= 0 && cyc >= m_free[k]) m_active[k] = 1'b0;
    if (!m_active[k]) begin
      elig  = r & ~m_blocked[k];
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && elig[(m_ptr[k] + i) % N]) begin
          found      = 1'b1;
          m_owner[k] = (m_ptr[k] + i) % N;
        end
      end
      if (found) begin
        m_active[k] = 1'b1;
        m_start[k]  = cyc;
        m_rel[k]    = -1;
        m_ptr[k]    = (m_owner[k] + 1) % N;
      end
    end else if (m_rel[k] < 0) begin
      if (cyc <= m_start[k] + S) begin
        if (!r[m_owner[k]]) begin
          m_rel[k]     = cyc;
          m_cs_high[k] = cyc;
          m_free[k]    = cyc + G + 1;
        end
      end else if (!r[m_owner[k]]) begin
        m_rel[k]     = cyc;
        m_cs_high[k] = cyc + H;
        m_free[k]    = cyc + H + G + 1;
      end else if (t_of(k) > 0 && cyc == m_start[k] + S + t_of(k)) begin
        m_rel[k]         = cyc;
        m_cs_high[k]     = cyc + H;
        m_free[k]        = cyc + H + G + 1;
        m_tmo_edge[k]    = cyc;
        set[m_owner[k]]  = 1'b1;
      end
    end
    m_blocked[k] = (m_blocked[k] | set) & r;
  endtask

  task automatic check_outputs(input int k);
    logic [N-1:0] g;
    logic [N-1:0] c;
    logic         es;
    logic         ec;
    bit           cs_low;
    g = '0;
    if (m_active[k] && m_rel[k] < 0 && cyc >= m_start[k] + S) g[m_owner[k]] = 1'b1;
    cs_low = m_active[k] && cyc >= m_start[k] && (m_rel[k] < 0 || cyc < m_cs_high[k]);
    check_eq($sformatf("gnt%0d@%0d", k, cyc), 32'(gnt[k]), 32'(g));
    check_eq($sformatf("cs_n%0d@%0d", k, cyc), 32'(cs_n[k]), 32'(!cs_low));
    check_eq($sformatf("timeout%0d@%0d", k, cyc), 32'(tmo[k]), 32'(cyc == m_tmo_edge[k]));
    check_eq($sformatf("owner%0d@%0d", k, cyc), 32'(owner[k]), 32'(m_owner[k]));
    c  = '0;
    es = 1'b0;
    ec = 1'b0;
    if (g != '0) begin
      c[m_owner[k]] = cipo_bus[k];
      es            = sclk_in[k][m_owner[k]];
      ec            = copi_in[k][m_owner[k]];
    end
    check_eq($sformatf("sclk%0d@%0d", k, cyc), 32'(sclk_bus[k]), 32'(es));
    check_eq($sformatf("copi%0d@%0d", k, cyc), 32'(copi_bus[k]), 32'(ec));
    check_eq($sformatf("cipo%0d@%0d", k, cyc), 32'(cipo_ret[k]), 32'(c));
  endtask

  task automatic cycle();
    logic [N-1:0] prev_g;
    logic [0:0]   want;
    prev_g = gnt[0];
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      else model_step(k, req[k]);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      sclk_in[k]  = N'($urandom);
      copi_in[k]  = N'($urandom);
      cipo_bus[k] = 1'($urandom);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check_outputs(k);
      if (gnt[k] != '0) gcnt[k]++;
      if (cs_n[k] == 1'b0) clow[k]++;
      if (tmo[k] == 1'b1) tcnt[k]++;
    end
    if (track_owner && prev_g == '0 && gnt[0] != '0 && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check_eq($sformatf("owner_seq@%0d", cyc), 32'(owner[0]), 32'(want));
    end
  endtask

  task automatic set_req(input logic [N-1:0] v);
    req[0] = v;
    req[1] = v;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      gcnt[k] = 0;
      clow[k] = 0;
      tcnt[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req('0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic rand_drive();
    bit mine;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        mine = m_active[k] && m_rel[k] < 0 && m_owner[k] == i;
        if (!req[k][i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[k][i]    = 1'b1;
            hold_left[k][i] = $urandom_range(1, 12);
          end
        end else if (mine && cyc >= m_start[k] + S) begin
          if (hold_left[k][i] <= 1) req[k][i] = 1'b0;
          else hold_left[k][i]--;
        end else if (mine) begin
          if ($urandom_range(0, 19) == 0) req[k][i] = 1'b0;
        end else if (m_blocked[k][i]) begin
          if ($urandom_range(0, 3) == 0) req[k][i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k]      = '0;
      sclk_in[k]  = '0;
      copi_in[k]  = '0;
      cipo_bus[k] = 1'b0;
      model_reset(k);
    end

    // Reset values are checked by the per-cycle model comparison.
    do_reset();

    // Single requester: grant cycles 3..20, CS low cycles 1..22; watchdog instance times out.
    clear_stats();
    set_req(2'b01);
    repeat (20) cycle();
    set_req(2'b00);
    repeat (6) cycle();
    check_eq("single_gnt_cycles", 32'(gcnt[0]), 32'd18);
    check_eq("single_cs_low_cycles", 32'(clow[0]), 32'd22);
    check_eq("single_wd_gnt_cycles", 32'(gcnt[1]), 32'd8);
    check_eq("single_wd_timeouts", 32'(tcnt[1]), 32'd1);

    // Abort during SETUP: request dropped in cycle 2.
    do_reset();
    clear_stats();
    set_req(2'b01);
    cycle();
    cycle();
    set_req(2'b00);
    repeat (4) cycle();
    check_eq("abort_gnt_cycles", 32'(gcnt[0]), 32'd0);
    check_eq("abort_cs_low_cycles", 32'(clow[0]), 32'd2);

    // Contention: both requesting, each owner releases after 5 granted cycles.
    do_reset();
    exp_q = {};
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    track_owner = 1'b1;
    set_req(2'b11);
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < N; i++) begin
          if (m_active[k] && m_rel[k] < 0 && m_owner[k] == i &&
              cyc - (m_start[k] + S) + 1 >= 5)
            req[k][i] = 1'b0;
          else
            req[k][i] = 1'b1;
        end
      end
    end
    track_owner = 1'b0;
    check_eq("contention_grants_seen", 32'(exp_q.size()), 32'd0);

    // Watchdog: 8 owned cycles, one pulse, no re-grant until req toggles.
    do_reset();
    clear_stats();
    set_req(2'b01);
    repeat (30) cycle();
    check_eq("wd_gnt_cycles", 32'(gcnt[1]), 32'd8);
    check_eq("wd_timeouts", 32'(tcnt[1]), 32'd1);
    clear_stats();
    set_req(2'b00);
    cycle();
    set_req(2'b01);
    repeat (6) cycle();
    check_eq("wd_regrant_cycles", 32'(gcnt[1]), 32'd4);
    check_eq("wd_no_second_timeout", 32'(tcnt[1]), 32'd0);

    // Reset while owning: grant and CS drop at once, pointer restarts at 0.
    do_reset();
    set_req(2'b01);
    repeat (6) cycle();
    rst = 1'b1;
    cycle();
    check_eq("rst_own_gnt", 32'(gnt[0]), 32'd0);
    check_eq("rst_own_cs_n", 32'(cs_n[0]), 32'd1);
    rst = 1'b0;
    set_req(2'b11);
    repeat (4) cycle();
    check_eq("rst_ptr_owner", 32'(owner[0]), 32'd0);
    check_eq("rst_ptr_gnt", 32'(gnt[0]), 32'd1);

    // Random soak on both instances.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rand_drive();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
